// File: rtl/int_seq_ctrl_if.sv
// int_seq_ctrl_if -- control bundle between the interrupt sequencer and the
// pipeline/decode logic of the 8-bit core.
//
// Signals (direction as seen from the sequencer):
//   intr         in   external interrupt request
//   rti_dec      in   single-cycle strobe, RTI decoded in the decode stage
//   stall_in     in   pipeline hazard stall, blocks starting a sequence
//   flush        out  squash fetch/decode pipeline registers
//   push_pc      out  decrement SP, write return PC to the stack
//   pop_pc       out  read PC from the stack, increment SP
//   copy_ccr     out  back up the current flags
//   paste_ccr    out  restore the backed-up flags
//   mem_addr_sel out  data-memory address is vec_addr
//   vec_addr     out  ISR vector location (constant, for the address mux)
//   pc_sel       out  00 PC+1, 01 vector data, 10 popped stack value
//   int_ack      out  one-cycle acknowledge, vector load in progress
//   in_isr       out  ISR active, further interrupts held pending
//   busy         out  sequencer not idle
//
// Modports: master = sequencer side, slave = pipeline side.
interface int_seq_ctrl_if;
  logic       intr;
  logic       rti_dec;
  logic       stall_in;
  logic       flush;
  logic       push_pc;
  logic       pop_pc;
  logic       copy_ccr;
  logic       paste_ccr;
  logic       mem_addr_sel;
  logic [7:0] vec_addr;
  logic [1:0] pc_sel;
  logic       int_ack;
  logic       in_isr;
  logic       busy;

  modport master (
    input  intr, rti_dec, stall_in,
    output flush, push_pc, pop_pc, copy_ccr, paste_ccr, mem_addr_sel,
           vec_addr, pc_sel, int_ack, in_isr, busy
  );

  modport slave (
    output intr, rti_dec, stall_in,
    input  flush, push_pc, pop_pc, copy_ccr, paste_ccr, mem_addr_sel,
           vec_addr, pc_sel, int_ack, in_isr, busy
  );
endinterface

// File: rtl/int_seq_ctrl.sv
// int_seq_ctrl -- interrupt / return-from-interrupt sequencer.
//
// Steps the pipeline through flush -> push PC -> save flags -> load vector on
// an interrupt, and pop PC -> restore flags on RTI. Sole driver of
// copy_ccr/paste_ccr; the two live in different states so they can never be
// asserted together.
//
// Ports:
//   clk  in  core clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  int_seq_ctrl_if.master (request inputs, pipeline control outputs)
// Parameter:
//   VEC_ADDR  data-memory address holding the ISR start address
//
// Configuration macro INTR_EDGE_EN:
//   defined   -> request is edge-triggered, pending cleared when the vector
//                is loaded (a new edge in that cycle wins)
//   undefined -> request is level-sensitive, pending follows intr each cycle
module int_seq_ctrl #(
  parameter logic [7:0] VEC_ADDR = 8'h01
) (
  input logic             clk,
  input logic             rst,
  int_seq_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_FLUSH = 3'd1,
    I_PUSH  = 3'd2,
    I_SAVE  = 3'd3,
    I_VEC   = 3'd4,
    R_POP   = 3'd5,
    R_REST  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic       pend_q, pend_d;
  logic       in_isr_q, in_isr_d;
  logic       flush_q, push_q, pop_q, copy_q, paste_q, mas_q, ack_q, busy_q;
  logic [1:0] pc_sel_q;

  // Next-state: RTI has priority and ignores stall; an interrupt needs a
  // pending request, no active ISR (one flag backup slot) and no stall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.rti_dec)                                  state_d = R_POP;
        else if (pend_q && !in_isr_q && !bus.stall_in)    state_d = I_FLUSH;
      end
      I_FLUSH: state_d = I_PUSH;
      I_PUSH:  state_d = I_SAVE;
      I_SAVE:  state_d = I_VEC;
      I_VEC:   state_d = IDLE;
      R_POP:   state_d = R_REST;
      R_REST:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_isr_d = in_isr_q;
    if (state_q == I_VEC)       in_isr_d = 1'b1;
    else if (state_q == R_REST) in_isr_d = 1'b0;
  end

`ifdef INTR_EDGE_EN
  logic intr_q;

  // Set on a rising edge of intr; clear when leaving I_VEC; set wins.
  always_comb begin
    pend_d = pend_q;
    if (bus.intr && !intr_q)    pend_d = 1'b1;
    else if (state_q == I_VEC)  pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) intr_q <= 1'b0;
    else     intr_q <= bus.intr;
  end
`else
  always_comb begin
    pend_d = bus.intr;
  end
`endif

  // Outputs are decoded from the next state and registered, so they are
  // valid for the whole cycle after the edge that enters each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      in_isr_q <= 1'b0;
      flush_q  <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      copy_q   <= 1'b0;
      paste_q  <= 1'b0;
      mas_q    <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      pc_sel_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      in_isr_q <= in_isr_d;
      flush_q  <= (state_d == I_FLUSH) || (state_d == I_PUSH) || (state_d == R_POP);
      push_q   <= (state_d == I_PUSH);
      pop_q    <= (state_d == R_POP);
      copy_q   <= (state_d == I_SAVE);
      paste_q  <= (state_d == R_REST);
      mas_q    <= (state_d == I_VEC);
      ack_q    <= (state_d == I_VEC);
      busy_q   <= (state_d != IDLE);
      if (state_d == I_VEC)       pc_sel_q <= 2'b01;
      else if (state_d == R_REST) pc_sel_q <= 2'b10;
      else                        pc_sel_q <= 2'b00;
    end
  end

  assign bus.flush        = flush_q;
  assign bus.push_pc      = push_q;
  assign bus.pop_pc       = pop_q;
  assign bus.copy_ccr     = copy_q;
  assign bus.paste_ccr    = paste_q;
  assign bus.mem_addr_sel = mas_q;
  assign bus.vec_addr     = VEC_ADDR;
  assign bus.pc_sel       = pc_sel_q;
  assign bus.int_ack      = ack_q;
  assign bus.in_isr       = in_isr_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_int_seq_ctrl.sv
// Testbench for int_seq_ctrl: directed scenarios followed by a random phase,
// every cycle compared against a step-queue reference model.
module tb_int_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int_seq_ctrl_if bus ();

  int_seq_ctrl #(.VEC_ADDR(8'h01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Step encoding: [10]flush [9]push [8]pop [7]copy [6]paste [5]mem_addr_sel
  // [4:3]pc_sel [2]int_ack [1]sets in_isr on exit [0]clears in_isr on exit
  localparam logic [10:0] S_FLUSH = 11'b1_0_0_0_0_0_00_0_0_0;
  localparam logic [10:0] S_PUSH  = 11'b1_1_0_0_0_0_00_0_0_0;
  localparam logic [10:0] S_SAVE  = 11'b0_0_0_1_0_0_00_0_0_0;
  localparam logic [10:0] S_VEC   = 11'b0_0_0_0_0_1_01_1_1_0;
  localparam logic [10:0] S_POP   = 11'b1_0_1_0_0_0_00_0_0_0;
  localparam logic [10:0] S_REST  = 11'b0_0_0_0_1_0_10_0_0_1;

  logic        m_pend = 1'b0, m_isr = 1'b0, m_intr_q = 1'b0, m_cur_v = 1'b0;
  logic [10:0] m_cur = '0;
  logic [10:0] mq[$];

  int n_chk = 0;
  int n_pass = 0;
  logic saw_copy;

  // Model update for one rising edge, using the inputs as currently driven.
  task automatic model_edge();
    logic old_pend, old_isr;
    if (rst) begin
      m_pend = 1'b0; m_isr = 1'b0; m_intr_q = 1'b0;
      m_cur_v = 1'b0; m_cur = '0; mq.delete();
      return;
    end
    old_pend = m_pend;
    old_isr  = m_isr;
`ifdef INTR_EDGE_EN
    if (bus.intr && !m_intr_q)    m_pend = 1'b1;
    else if (m_cur_v && m_cur[1]) m_pend = 1'b0;
    m_intr_q = bus.intr;
`else
    m_pend = bus.intr;
`endif
    if (m_cur_v) begin
      if (m_cur[1]) m_isr = 1'b1;
      if (m_cur[0]) m_isr = 1'b0;
      if (mq.size() > 0) m_cur = mq.pop_front();
      else begin m_cur_v = 1'b0; m_cur = '0; end
    end else if (bus.rti_dec) begin
      mq = {S_REST};
      m_cur = S_POP; m_cur_v = 1'b1;
    end else if (old_pend && !old_isr && !bus.stall_in) begin
      mq = {S_PUSH, S_SAVE, S_VEC};
      m_cur = S_FLUSH; m_cur_v = 1'b1;
    end
  endtask

  // Observed layout: [10]flush [9]push [8]pop [7]copy [6]paste [5]mas
  // [4:3]pc_sel [2]int_ack [1]in_isr [0]busy
  function automatic logic [10:0] obs();
    return {bus.flush, bus.push_pc, bus.pop_pc, bus.copy_ccr, bus.paste_ccr,
            bus.mem_addr_sel, bus.pc_sel, bus.int_ack, bus.in_isr, bus.busy};
  endfunction

  function automatic logic [10:0] expv();
    return {m_cur[10:2], m_isr, m_cur_v};
  endfunction

  task automatic chk(input string tag, input logic [10:0] o, input logic [10:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, o, e);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    if (bus.copy_ccr === 1'b1) saw_copy = 1'b1;
    chk(tag, obs(), expv());
    chk({tag, "_ccr_excl"}, {10'd0, bus.copy_ccr & bus.paste_ccr}, 11'd0);
  endtask

  initial begin
    bus.intr = 1'b0; bus.rti_dec = 1'b0; bus.stall_in = 1'b0;
    saw_copy = 1'b0;

    // Reset state
    rst = 1'b1;
    step("reset0");
    step("reset1");
    chk("reset_const", obs(), 11'd0);
    chk("vec_addr", {3'd0, bus.vec_addr}, 11'h001);
    rst = 1'b0;
    step("idle0");

    // Basic interrupt: intr 0->1, unstalled
    bus.intr = 1'b1;
    step("E0");
    bus.intr = 1'b0;
    step("E1"); chk("E1_const", obs(), 11'b1_0_0_0_0_0_00_0_0_1);
    step("E2"); chk("E2_const", obs(), 11'b1_1_0_0_0_0_00_0_0_1);
    step("E3"); chk("E3_const", obs(), 11'b0_0_0_1_0_0_00_0_0_1);
    step("E4"); chk("E4_const", obs(), 11'b0_0_0_0_0_1_01_1_0_1);
    step("E5"); chk("E5_const", obs(), 11'b0_0_0_0_0_0_00_0_1_0);
    step("isr_idle");

    // RTI from the ISR
    bus.rti_dec = 1'b1;
    step("rti0"); chk("rti_pop_const", obs(), 11'b1_0_1_0_0_0_00_0_1_1);
    bus.rti_dec = 1'b0;
    step("rti1"); chk("rti_rest_const", obs(), 11'b0_0_0_0_1_0_10_0_1_1);
    step("rti2"); chk("rti_done_const", obs(), 11'd0);

    // Interrupt held off by 3 stalled edges
    bus.stall_in = 1'b1; bus.intr = 1'b1;
    step("st_E0");
    for (int i = 0; i < 3; i++) step("st_hold");
    bus.stall_in = 1'b0;
    step("st_flush"); chk("st_flush_const", obs(), 11'b1_0_0_0_0_0_00_0_0_1);
    for (int i = 0; i < 5; i++) step("st_seq");

    // Second request while in ISR, then RTI -> second ISR entry
    bus.intr = 1'b0;
    step("nest_lo");
    bus.intr = 1'b1;
    step("nest_hi");
    step("nest_wait");
    bus.rti_dec = 1'b1;
    step("nest_rti");
    bus.rti_dec = 1'b0;
    for (int i = 0; i < 8; i++) step("nest_seq");
    bus.intr = 1'b0;
    step("nest_end");

    // RTI and a new request edge on the same idle edge, in_isr=1
    bus.intr = 1'b0;
    step("same_lo");
    bus.intr = 1'b1; bus.rti_dec = 1'b1;
    step("same_E");
    bus.rti_dec = 1'b0;
    for (int i = 0; i < 8; i++) step("same_seq");
    bus.intr = 1'b0;
    step("same_lo2");
    bus.rti_dec = 1'b1;
    step("clean_rti");
    bus.rti_dec = 1'b0;
    for (int i = 0; i < 3; i++) step("clean_seq");

    // Reset at the edge that would enter I_SAVE
    saw_copy = 1'b0;
    bus.intr = 1'b1;
    step("rs_E0");
    bus.intr = 1'b0;
    step("rs_E1");
    step("rs_E2");
    rst = 1'b1;
    step("rs_E3");
    chk("rs_zero_const", obs(), 11'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("rs_after");
    chk("rs_no_copy", {10'd0, saw_copy}, 11'd0);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus.intr = ~bus.intr;
      bus.rti_dec  = ($urandom_range(0, 9) == 0);
      bus.stall_in = ($urandom_range(0, 3) == 0);
      rst          = ($urandom_range(0, 149) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
